// File: rtl/inst_queue.sv
// Decoupling FIFO between fetch and decode. It captures {inst, pc} one cycle after
// each fetch completes, presents the head entry to decode, and back-pressures fetch.
module inst_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_fetch_done,
   input  logic [DATA_WIDTH-1:0]   i_fetch_pc,
   input  logic [DATA_WIDTH-1:0]   i_inst,
   output logic                    o_stall,
   input  logic                    i_flush,
   output logic                    o_valid,
   output logic [DATA_WIDTH-1:0]   o_inst,
   output logic [DATA_WIDTH-1:0]   o_pc,
   input  logic                    i_ready,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W:0] STALL_LVL = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic                  pending_q, pending_d;
   logic [DATA_WIDTH-1:0] pc_hold_q, pc_hold_d;
   logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] inst_mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem_q   [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem_d   [DEPTH];

   logic [PTR_W-1:0] count;
   logic [PTR_W:0]   occupancy;
   logic             empty;
   logic             wr_en;
   logic             deq_en;

   always_comb begin
      count     = tail_q - head_q;
      empty     = (tail_q == head_q);
      // Stall counts the in-flight pending entry and ignores a same-cycle dequeue,
      // so a write can never land on a full queue.
      occupancy = {1'b0, count} + {{PTR_W{1'b0}}, pending_q};
      o_stall   = (occupancy >= STALL_LVL);
      o_valid   = !empty;
      o_count   = count;
      o_inst    = '0;
      o_pc      = '0;
      if (!empty) begin
         o_inst = inst_mem_q[head_q[IDX_W-1:0]];
         o_pc   = pc_mem_q[head_q[IDX_W-1:0]];
      end
   end

   always_comb begin
      wr_en      = pending_q && !i_flush;
      deq_en     = !empty && i_ready && !i_flush;
      pending_d  = i_fetch_done && !i_flush;
      pc_hold_d  = i_fetch_done ? i_fetch_pc : pc_hold_q;
      head_d     = head_q + {{(PTR_W-1){1'b0}}, deq_en};
      tail_d     = tail_q + {{(PTR_W-1){1'b0}}, wr_en};
      if (i_flush) begin
         head_d = '0;
         tail_d = '0;
      end
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;
      if (wr_en) begin
         inst_mem_d[tail_q[IDX_W-1:0]] = i_inst;
         pc_mem_d[tail_q[IDX_W-1:0]]   = pc_hold_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         pending_q <= pending_d;
      end
   end

   // Storage and the held PC carry data only; validity is tracked by the pointers.
   always_ff @(posedge i_clk) begin
      pc_hold_q  <= pc_hold_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
   end

endmodule
